// File: rtl/divider_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | divider_arbiter                                                          |
// | Round-robin sharing of one multi-cycle divider between N requesters.     |
// | Optional DIV_RESULT_CACHE_EN: one-entry result cache skipping the divider.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module divider_arbiter #(
  parameter int NR_OF_REQUESTERS = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NR_OF_REQUESTERS-1:0]     request,
  input  logic [NR_OF_REQUESTERS-1:0]     signedIn,
  input  logic [32*NR_OF_REQUESTERS-1:0]  operandAIn,
  input  logic [32*NR_OF_REQUESTERS-1:0]  operandBIn,
  output logic [NR_OF_REQUESTERS-1:0]     accept,
  output logic [NR_OF_REQUESTERS-1:0]     done,
  output logic [31:0]                     quotientOut,
  output logic                            divideByZero,
  output logic                            busy,
  output logic                            divDoDivide,
  output logic                            divSigned,
  output logic [31:0]                     divOperandA,
  output logic [31:0]                     divOperandB,
  input  logic                            divReady,
  input  logic                            divCarryOut,
  input  logic [31:0]                     divQuotient
);

  localparam int c_IDX_W = $clog2(NR_OF_REQUESTERS);

`ifdef DIV_RESULT_CACHE_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_HIT   = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;
`endif

  state_t                 r_state;
  state_t                 w_nextState;
  logic [c_IDX_W-1:0]     r_pointer;
  logic [c_IDX_W-1:0]     r_winner;
  logic [c_IDX_W-1:0]     w_cand;
  logic [c_IDX_W-1:0]     w_grantIdx;
  logic                   w_grantValid;
  logic                   w_grantSigned;
  logic [31:0]            w_grantA;
  logic [31:0]            w_grantB;

  function automatic logic [NR_OF_REQUESTERS-1:0] oneHot(input logic [c_IDX_W-1:0] idx);
    oneHot      = '0;
    oneHot[idx] = 1'b1;
  endfunction

  // Walk downward in priority so the requester closest to the pointer is assigned last.
  always_comb begin
    w_grantValid = 1'b0;
    w_grantIdx   = '0;
    w_cand       = '0;
    for (int i = NR_OF_REQUESTERS - 1; i >= 0; i--) begin
      w_cand = c_IDX_W'((int'(r_pointer) + i) % NR_OF_REQUESTERS);
      if (request[w_cand]) begin
        w_grantValid = 1'b1;
        w_grantIdx   = w_cand;
      end
    end
  end

  assign w_grantSigned = signedIn[w_grantIdx];
  assign w_grantA      = operandAIn[32*w_grantIdx +: 32];
  assign w_grantB      = operandBIn[32*w_grantIdx +: 32];

`ifdef DIV_RESULT_CACHE_EN
  logic        r_cacheValid;
  logic        r_cacheSigned;
  logic [31:0] r_cacheA;
  logic [31:0] r_cacheB;
  logic [31:0] r_cacheQ;
  logic        r_cacheCarry;
  logic        w_cacheHit;

  assign w_cacheHit = r_cacheValid && (r_cacheSigned == w_grantSigned) &&
                      (r_cacheA == w_grantA) && (r_cacheB == w_grantB);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cacheValid  <= 1'b0;
      r_cacheSigned <= 1'b0;
      r_cacheA      <= '0;
      r_cacheB      <= '0;
      r_cacheQ      <= '0;
      r_cacheCarry  <= 1'b0;
    end else if (r_state == S_DONE) begin
      r_cacheValid  <= 1'b1;
      r_cacheSigned <= divSigned;
      r_cacheA      <= divOperandA;
      r_cacheB      <= divOperandB;
      r_cacheQ      <= quotientOut;
      r_cacheCarry  <= divideByZero;
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grantValid) begin
`ifdef DIV_RESULT_CACHE_EN
          w_nextState = w_cacheHit ? S_HIT : S_ISSUE;
`else
          w_nextState = S_ISSUE;
`endif
        end
      end
      S_ISSUE: w_nextState = S_WAIT;
      S_WAIT:  if (divReady) w_nextState = S_DONE;
      S_DONE:  w_nextState = S_IDLE;
`ifdef DIV_RESULT_CACHE_EN
      S_HIT:   w_nextState = S_DONE;
`endif
      default: w_nextState = S_IDLE;
    endcase
  end

  assign busy = (r_state != S_IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      accept       <= '0;
      done         <= '0;
      quotientOut  <= '0;
      divideByZero <= 1'b0;
      divDoDivide  <= 1'b0;
      divSigned    <= 1'b0;
      divOperandA  <= '0;
      divOperandB  <= '0;
      r_pointer    <= '0;
      r_winner     <= '0;
    end else begin
      accept      <= '0;
      done        <= '0;
      divDoDivide <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grantValid) begin
            r_winner    <= w_grantIdx;
            divSigned   <= w_grantSigned;
            divOperandA <= w_grantA;
            divOperandB <= w_grantB;
            accept      <= oneHot(w_grantIdx);
`ifdef DIV_RESULT_CACHE_EN
            divDoDivide <= !w_cacheHit;
`else
            divDoDivide <= 1'b1;
`endif
          end
        end
        S_WAIT: begin
          if (divReady) begin
            quotientOut  <= divQuotient;
            divideByZero <= divCarryOut;
            done         <= oneHot(r_winner);
          end
        end
        S_DONE: begin
          r_pointer <= (r_winner == c_IDX_W'(NR_OF_REQUESTERS - 1)) ? '0 : r_winner + 1'b1;
        end
`ifdef DIV_RESULT_CACHE_EN
        S_HIT: begin
          quotientOut  <= r_cacheQ;
          divideByZero <= r_cacheCarry;
          done         <= oneHot(r_winner);
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_divider_arbiter.sv
`default_nettype none
// Directed bench for divider_arbiter with a behavioural multi-cycle divider model.
module tb_divider_arbiter;
  localparam int N = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    request, signedIn, accept, done;
  logic [32*N-1:0] operandAIn, operandBIn;
  logic [31:0]     quotientOut, divOperandA, divOperandB, divQuotient;
  logic            divideByZero, busy, divDoDivide, divSigned, divReady, divCarryOut;

  int checks = 0;
  int errors = 0;
  int divLatency = 4;

  divider_arbiter #(.NR_OF_REQUESTERS(N)) dut (
    .clock(clock), .reset(reset), .request(request), .signedIn(signedIn),
    .operandAIn(operandAIn), .operandBIn(operandBIn), .accept(accept), .done(done),
    .quotientOut(quotientOut), .divideByZero(divideByZero), .busy(busy),
    .divDoDivide(divDoDivide), .divSigned(divSigned), .divOperandA(divOperandA),
    .divOperandB(divOperandB), .divReady(divReady), .divCarryOut(divCarryOut),
    .divQuotient(divQuotient)
  );

  always #5 clock = ~clock;

  function automatic logic [32:0] divModel(input logic s, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return {1'b1, 32'hFFFF_FFFF};
    if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'h8000_0000};
      return {1'b0, 32'($signed(a) / $signed(b))};
    end
    return {1'b0, a / b};
  endfunction

  int          mCount;
  logic        mActive;
  logic [32:0] mResult;
  always @(posedge clock) begin
    if (reset) begin
      mActive <= 1'b0; mCount <= 0; divReady <= 1'b0;
      divQuotient <= '0; divCarryOut <= 1'b0; mResult <= '0;
    end else begin
      divReady <= 1'b0;
      if (divDoDivide) begin
        mActive <= 1'b1;
        mCount  <= divLatency;
        mResult <= divModel(divSigned, divOperandA, divOperandB);
      end else if (mActive) begin
        if (mCount <= 1) begin
          mActive     <= 1'b0;
          divReady    <= 1'b1;
          divQuotient <= mResult[31:0];
          divCarryOut <= mResult[32];
        end else begin
          mCount <= mCount - 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int idx, input logic s, input logic [31:0] a, input logic [31:0] b);
    request[idx] = 1'b1;
    signedIn[idx] = s;
    operandAIn[32*idx +: 32] = a;
    operandBIn[32*idx +: 32] = b;
  endtask

  // One complete transaction from a single requester through the divider.
  task automatic runOne(input string name, input int idx, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] expQ, input logic expDz);
    logic [N-1:0] m;
    int cyc, pulses;
    bit got;
    m = '0; m[idx] = 1'b1;
    @(negedge clock);
    drive(idx, s, a, b);
    @(negedge clock);
    check({name, "_accept"}, accept, m);
    check({name, "_issue"}, {divDoDivide, busy}, 2'b11);
    request[idx] = 1'b0;
    pulses = 1; cyc = 0; got = 0;
    while (!got && cyc < 300) begin
      @(negedge clock);
      cyc++;
      if (divDoDivide) pulses++;
      if (done != '0) got = 1;
    end
    check({name, "_done_seen"}, got, 1);
    check({name, "_done"}, done, m);
    check({name, "_quot"}, quotientOut, expQ);
    check({name, "_dz"}, divideByZero, expDz);
    check({name, "_pulses"}, pulses, 1);
    @(negedge clock);
    check({name, "_idle"}, {busy, done}, '0);
  endtask

  typedef struct {
    string       name;
    int          idx;
    logic        s;
    logic [31:0] a, b, q;
    logic        dz;
  } vec_t;

  vec_t vecs[7];
  int   rrOrder[5] = '{0, 1, 2, 3, 0};
  logic [31:0] rrQ[4] = '{32'd20, 32'd15, 32'd13, 32'd12};

  initial begin
    vecs[0] = '{"u100_7",   0, 1'b0, 32'd100,       32'd7,          32'd14,         1'b0};
    vecs[1] = '{"sneg100",  1, 1'b1, 32'hFFFFFF9C,  32'd7,          32'hFFFFFFF2,   1'b0};
    vecs[2] = '{"sovf",     1, 1'b1, 32'h80000000,  32'hFFFFFFFF,   32'h80000000,   1'b0};
    vecs[3] = '{"dz12345",  2, 1'b0, 32'd12345,     32'd0,          32'hFFFFFFFF,   1'b1};
    vecs[4] = '{"umax_2",   3, 1'b0, 32'hFFFFFFFF,  32'd2,          32'h7FFFFFFF,   1'b0};
    vecs[5] = '{"s7_m2",    2, 1'b1, 32'd7,         32'hFFFFFFFE,   32'hFFFFFFFD,   1'b0};
    vecs[6] = '{"sdz",      0, 1'b1, 32'hFFFFFFF9,  32'd0,          32'hFFFFFFFF,   1'b1};

    reset = 1'b1; request = '0; signedIn = '0; operandAIn = '0; operandBIn = '0;
    repeat (3) @(negedge clock);
    check("rst_ctl", {accept, done, divDoDivide, busy, divideByZero, divSigned}, '0);
    check("rst_q", quotientOut, 32'd0);
    check("rst_ops", {divOperandA, divOperandB}, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++)
      runOne(vecs[i].name, vecs[i].idx, vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].dz);

    // All four requesting straight out of reset: strict rotation, one grant at a time.
    begin
      int k, d, cyc;
      logic [N-1:0] m;
      @(negedge clock);
      reset = 1'b1;
      for (int i = 0; i < N; i++) drive(i, 1'b0, 32'(20 + 10 * i), 32'(i + 1));
      repeat (2) @(negedge clock);
      reset = 1'b0;
      k = 0; d = 0; cyc = 0;
      while (k < 5 && cyc < 1000) begin
        @(negedge clock);
        cyc++;
        if (accept != '0) begin
          m = '0; m[rrOrder[k]] = 1'b1;
          check("rr_accept", accept, m);
          k++;
        end
        if (done != '0 && d < 4) begin
          m = '0; m[rrOrder[d]] = 1'b1;
          check("rr_done", done, m);
          check("rr_quot", quotientOut, rrQ[rrOrder[d]]);
          d++;
        end
      end
      check("rr_accept_count", k, 5);
      check("rr_done_count", d, 4);
      request = '0;
      cyc = 0;
      while (busy && cyc < 300) begin @(negedge clock); cyc++; end
      check("rr_drain", busy, 1'b0);
    end

    // Reset ten cycles into WAIT aborts the operation with no done.
    begin
      int sawDone;
      divLatency = 40;
      @(negedge clock);
      drive(1, 1'b0, 32'd100, 32'd7);
      @(negedge clock);
      check("abort_accept", accept, 4'b0010);
      request = '0;
      repeat (11) @(negedge clock);
      check("abort_in_wait", {busy, divDoDivide, done}, {1'b1, 1'b0, 4'b0000});
      reset = 1'b1;
      @(negedge clock);
      check("abort_rst_ctl", {accept, done, divDoDivide, busy, divideByZero, divSigned}, '0);
      check("abort_rst_q", quotientOut, 32'd0);
      check("abort_rst_ops", {divOperandA, divOperandB}, 64'd0);
      reset = 1'b0;
      sawDone = 0;
      repeat (60) begin @(negedge clock); if (done != '0 || busy) sawDone++; end
      check("abort_no_done", sawDone, 0);
      divLatency = 4;
      runOne("fresh", 2, 1'b0, 32'd100, 32'd7, 32'd14, 1'b0);
    end

`ifdef DIV_RESULT_CACHE_EN
    begin
      int pulses;
      @(negedge clock);
      drive(3, 1'b0, 32'd100, 32'd7);
      pulses = 0;
      @(negedge clock);
      if (divDoDivide) pulses++;
      check("hit_accept", accept, 4'b1000);
      request = '0;
      @(negedge clock);
      if (divDoDivide) pulses++;
      check("hit_done", done, 4'b1000);
      check("hit_quot", quotientOut, 32'd14);
      check("hit_dz", divideByZero, 1'b0);
      @(negedge clock);
      if (divDoDivide) pulses++;
      check("hit_no_issue", pulses, 0);
      runOne("miss_signed", 3, 1'b1, 32'd100, 32'd7, 32'd14, 1'b0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
